// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access stage: bus SIZE codes,
// funct3 access types and the access FSM states.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b11;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b00;

   // funct3[1:0] carries the access width for both loads and stores
   localparam logic [1:0] W_BYTE = 2'b00;
   localparam logic [1:0] W_HALF = 2'b01;
   localparam logic [1:0] W_WORD = 2'b10;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane helper: store lane replication, alignment check,
// bus SIZE encoding and load lane extraction with sign/zero extension.
module mem_align
   import mem_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]      req_width,
   input  logic [1:0]      req_off,
   input  logic [XLEN-1:0] store_data,
   input  logic [2:0]      ld_funct3,
   input  logic [1:0]      ld_off,
   input  logic [XLEN-1:0] bus_data,
   output logic [1:0]      size,
   output logic            aligned,
   output logic [XLEN-1:0] lane_data,
   output logic [XLEN-1:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      size      = SZ_WORD;
      aligned   = (req_off == 2'b00);
      lane_data = store_data;
      case (req_width)
         W_BYTE: begin
            size      = SZ_BYTE;
            aligned   = 1'b1;
            lane_data = {(XLEN/8){store_data[7:0]}};
         end
         W_HALF: begin
            size      = SZ_HALF;
            aligned   = ~req_off[0];
            lane_data = {(XLEN/16){store_data[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      byte_sel = bus_data[7:0];
      case (ld_off)
         2'd1:    byte_sel = bus_data[15:8];
         2'd2:    byte_sel = bus_data[23:16];
         2'd3:    byte_sel = bus_data[31:24];
         default: ;
      endcase
      half_sel = ld_off[1] ? bus_data[31:16] : bus_data[15:0];
      case (ld_funct3)
         F3_LB:   load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         F3_LH:   load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
         F3_LBU:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
         F3_LHU:  load_data = {{(XLEN-16){1'b0}}, half_sel};
         default: load_data = bus_data;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Data-memory access stage: issues one handshaked bus transaction per
// load/store, stalls the pipeline while it is outstanding, aborts on timeout.
//
// state | meaning
// IDLE  | no transaction; evaluates the EX/MEM request
// BUSY  | MREQ asserted, waiting for ACKD_n low or timeout
// DONE  | one-cycle completion, pipeline released
module mem_stage
   import mem_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] alu_out_data,
   input  logic [XLEN-1:0] reg_data2,
   input  logic            ACKD_n,
   input  logic [XLEN-1:0] ddt_in,
   output logic [XLEN-1:0] ddt_out,
   output logic            ddt_oe,
   output logic [XLEN-1:0] DAD,
   output logic            MREQ,
   output logic            WRITE,
   output logic [1:0]      SIZE,
   output logic [XLEN-1:0] mem_data,
   output logic            done,
   output logic            stall,
   output logic            misaligned,
   output logic            bus_error
);

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            state, state_nx;
   logic              acc, aligned;
   logic              accept, reject, ack_hit, tmo_hit;
   logic [CNT_W-1:0]  cnt;
   logic [1:0]        off_q;
   logic [2:0]        f3_q;
   logic [1:0]        size_req;
   logic [XLEN-1:0]   lane_data, load_val;

   assign acc = req_valid & (mem_read | mem_write);

   mem_align #(.XLEN(XLEN)) u_align (
      .req_width  (funct3[1:0]),
      .req_off    (alu_out_data[1:0]),
      .store_data (reg_data2),
      .ld_funct3  (f3_q),
      .ld_off     (off_q),
      .bus_data   (ddt_in),
      .size       (size_req),
      .aligned    (aligned),
      .lane_data  (lane_data),
      .load_data  (load_val)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      stall    = 1'b0;
      accept   = 1'b0;
      reject   = 1'b0;
      ack_hit  = 1'b0;
      tmo_hit  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (acc) begin
               if (aligned) begin
                  accept   = 1'b1;
                  stall    = 1'b1;
                  state_nx = ST_BUSY;
               end else begin
                  reject = 1'b1;
               end
            end
         end
         ST_BUSY: begin
            stall = 1'b1;
            if (!ACKD_n) begin
               ack_hit  = 1'b1;
               state_nx = ST_DONE;
            end else if (cnt == TMO_LAST) begin
               tmo_hit  = 1'b1;
               state_nx = ST_DONE;
            end
         end
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // mem_read & mem_write together is a store, so WRITE follows mem_write alone
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         DAD        <= '0;
         ddt_out    <= '0;
         ddt_oe     <= 1'b0;
         MREQ       <= 1'b0;
         WRITE      <= 1'b0;
         SIZE       <= 2'b00;
         mem_data   <= '0;
         done       <= 1'b0;
         misaligned <= 1'b0;
         bus_error  <= 1'b0;
         cnt        <= '0;
         off_q      <= 2'b00;
         f3_q       <= 3'b000;
      end else begin
         done       <= ack_hit | tmo_hit;
         bus_error  <= tmo_hit;
         misaligned <= reject;
         if (accept) begin
            DAD     <= {alu_out_data[XLEN-1:2], 2'b00};
            SIZE    <= size_req;
            WRITE   <= mem_write;
            off_q   <= alu_out_data[1:0];
            f3_q    <= funct3;
            ddt_out <= lane_data;
            ddt_oe  <= mem_write;
            MREQ    <= 1'b1;
            cnt     <= '0;
         end
         if (ack_hit) begin
            MREQ   <= 1'b0;
            ddt_oe <= 1'b0;
            if (!WRITE) mem_data <= load_val;
         end else if (tmo_hit) begin
            MREQ     <= 1'b0;
            ddt_oe   <= 1'b0;
            mem_data <= '0;
         end else if (state == ST_BUSY) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: transaction-level model predicts every cycle's outputs;
// directed cases pin literal results, then randomized loads/stores.
module tb_mem_stage;
   import mem_pkg::*;

   localparam int T = 6;

   logic        clk, rst, req_valid, mem_read, mem_write, ACKD_n;
   logic [2:0]  funct3;
   logic [31:0] alu_out_data, reg_data2, ddt_in;
   logic [31:0] ddt_out, DAD, mem_data;
   logic        ddt_oe, MREQ, WRITE, done, stall, misaligned, bus_error;
   logic [1:0]  SIZE;

   mem_stage #(.XLEN(32), .TIMEOUT_CYCLES(T), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .mem_read(mem_read),
      .mem_write(mem_write), .funct3(funct3), .alu_out_data(alu_out_data),
      .reg_data2(reg_data2), .ACKD_n(ACKD_n), .ddt_in(ddt_in),
      .ddt_out(ddt_out), .ddt_oe(ddt_oe), .DAD(DAD), .MREQ(MREQ),
      .WRITE(WRITE), .SIZE(SIZE), .mem_data(mem_data), .done(done),
      .stall(stall), .misaligned(misaligned), .bus_error(bus_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic        chk_en;
   logic        exp_mreq, exp_oe, exp_stall, exp_done, exp_mis, exp_berr, exp_write;
   logic [31:0] exp_data, exp_dad, exp_dout, m_data;
   logic [1:0]  exp_size;
   int          stall_cnt, mreq_cnt, done_cnt, mis_cnt, berr_cnt;
   logic [31:0] busy_dad, busy_dout;
   logic [1:0]  busy_size;
   logic        busy_oe, busy_write;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("MREQ", 32'(MREQ), 32'(exp_mreq));
         cmp("ddt_oe", 32'(ddt_oe), 32'(exp_oe));
         cmp("stall", 32'(stall), 32'(exp_stall));
         cmp("done", 32'(done), 32'(exp_done));
         cmp("misaligned", 32'(misaligned), 32'(exp_mis));
         cmp("bus_error", 32'(bus_error), 32'(exp_berr));
         cmp("mem_data", mem_data, exp_data);
         if (exp_mreq) begin
            cmp("DAD", DAD, exp_dad);
            cmp("SIZE", 32'(SIZE), 32'(exp_size));
            cmp("WRITE", 32'(WRITE), 32'(exp_write));
            if (exp_write) cmp("ddt_out", ddt_out, exp_dout);
         end
         stall_cnt += int'(stall);
         mreq_cnt  += int'(MREQ);
         done_cnt  += int'(done);
         mis_cnt   += int'(misaligned);
         berr_cnt  += int'(bus_error);
         if (MREQ) begin
            busy_dad   = DAD;
            busy_dout  = ddt_out;
            busy_size  = SIZE;
            busy_oe    = ddt_oe;
            busy_write = WRITE;
         end
      end
   end

   task automatic clr_cnt();
      stall_cnt = 0; mreq_cnt = 0; done_cnt = 0; mis_cnt = 0; berr_cnt = 0;
   endtask

   task automatic set_quiet();
      exp_mreq = 0; exp_oe = 0; exp_stall = 0; exp_done = 0;
      exp_mis = 0; exp_berr = 0; exp_data = m_data;
   endtask

   function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rd);
      logic [31:0] v;
      case (f3)
         F3_LB:  begin v = (rd >> (8*off)) & 32'hFF;  if (v >= 32'h80)   v = v - 32'h100;   end
         F3_LBU: v = (rd >> (8*off)) & 32'hFF;
         F3_LH:  begin v = (rd >> (16*off[1])) & 32'hFFFF; if (v >= 32'h8000) v = v - 32'h10000; end
         F3_LHU: v = (rd >> (16*off[1])) & 32'hFFFF;
         default: v = rd;
      endcase
      return v;
   endfunction

   // one request; d = BUSY cycles with ACKD_n high before it goes low
   task automatic txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata, input int d);
      logic [1:0]  wid, off, sz;
      logic        ok, tmo;
      logic [31:0] lanes;
      int          n;
      wid = f3[1:0];
      off = addr[1:0];
      sz  = (wid == 2'b00) ? 2'b11 : (wid == 2'b01) ? 2'b01 : 2'b00;
      ok  = (wid == 2'b00) || (wid == 2'b01 && !addr[0]) || (wid == 2'b10 && off == 2'b00);
      lanes = (wid == 2'b00) ? (wdata & 32'hFF) * 32'h01010101 :
              (wid == 2'b01) ? (wdata & 32'hFFFF) * 32'h00010001 : wdata;
      tmo = (d >= T);
      n   = tmo ? T : d + 1;

      @(posedge clk); #1;
      req_valid = 1; mem_write = wr; mem_read = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      funct3 = f3; alu_out_data = addr; reg_data2 = wdata;
      ACKD_n = 1'($urandom); ddt_in = $urandom;
      set_quiet(); exp_stall = ok;

      if (!ok) begin
         @(posedge clk); #1;
         req_valid = 0; ACKD_n = 1'($urandom);
         set_quiet(); exp_mis = 1;
         return;
      end

      for (int k = 1; k <= n; k++) begin
         @(posedge clk); #1;
         ACKD_n = (k == d + 1) ? 1'b0 : 1'b1;
         ddt_in = (k == d + 1) ? rdata : $urandom;
         set_quiet();
         exp_mreq = 1; exp_oe = wr; exp_stall = 1;
         exp_dad = addr & 32'hFFFF_FFFC; exp_size = sz; exp_write = wr; exp_dout = lanes;
      end

      if (tmo)      m_data = 0;
      else if (!wr) m_data = load_model(f3, off, rdata);
      @(posedge clk); #1;
      // a request shown in DONE must be ignored
      req_valid = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
      funct3 = 3'($urandom); alu_out_data = $urandom; ACKD_n = 1'($urandom); ddt_in = $urandom;
      set_quiet(); exp_done = 1; exp_berr = tmo;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         req_valid = 1'($urandom); mem_read = 0; mem_write = 0;
         funct3 = 3'($urandom); alu_out_data = $urandom; ACKD_n = 1'($urandom); ddt_in = $urandom;
         set_quiet();
      end
   endtask

   task automatic settle();
      @(negedge clk); #1;
   endtask

   logic [2:0] st_f3 [3];
   logic [2:0] ld_f3 [5];

   initial begin
      st_f3 = '{F3_SB, F3_SH, F3_SW};
      ld_f3 = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
      chk_en = 0; m_data = 0; clr_cnt();
      busy_dad = 0; busy_dout = 0; busy_size = 0; busy_oe = 0; busy_write = 0;
      req_valid = 0; mem_read = 0; mem_write = 0; funct3 = 0;
      alu_out_data = 0; reg_data2 = 0; ACKD_n = 1; ddt_in = 0;
      rst = 1;
      #2 rst = 0;
      #1;
      cmp("rst MREQ", 32'(MREQ), 0);
      cmp("rst ddt_oe", 32'(ddt_oe), 0);
      cmp("rst DAD", DAD, 0);
      cmp("rst ddt_out", ddt_out, 0);
      cmp("rst mem_data", mem_data, 0);
      cmp("rst done", 32'(done), 0);
      cmp("rst stall", 32'(stall), 0);
      cmp("rst SIZE", 32'(SIZE), 0);
      repeat (2) @(posedge clk);
      #3 rst = 1;
      set_quiet(); chk_en = 1;

      // SW word store, immediate ack
      clr_cnt();
      txn(1, F3_SW, 32'h100, 32'hDEADBEEF, 32'h0, 0); settle();
      cmp("sw stall cycles", 32'(stall_cnt), 2);
      cmp("sw done count", 32'(done_cnt), 1);
      cmp("sw MREQ cycles", 32'(mreq_cnt), 1);
      cmp("sw DAD", busy_dad, 32'h100);
      cmp("sw ddt_out", busy_dout, 32'hDEADBEEF);
      cmp("sw SIZE", 32'(busy_size), 0);
      cmp("sw ddt_oe", 32'(busy_oe), 1);
      idle(1);

      // LB / LBU top byte
      txn(0, F3_LB, 32'h203, 32'h0, 32'h80FF0000, 0); settle();
      cmp("lb mem_data", mem_data, 32'hFFFFFF80);
      cmp("lb DAD", busy_dad, 32'h200);
      cmp("lb SIZE", 32'(busy_size), 32'h3);
      txn(0, F3_LBU, 32'h203, 32'h0, 32'h80FF0000, 0); settle();
      cmp("lbu mem_data", mem_data, 32'h00000080);

      // LH upper half with 5 wait cycles
      clr_cnt();
      txn(0, F3_LH, 32'h002, 32'h0, 32'h1234ABCD, 5); settle();
      cmp("lh mem_data", mem_data, 32'h00001234);
      cmp("lh stall cycles", 32'(stall_cnt), 7);
      cmp("lh done count", 32'(done_cnt), 1);

      // misaligned word load and half store
      clr_cnt();
      txn(0, F3_LW, 32'h101, 32'h0, 32'h0, 0); settle();
      txn(1, F3_SH, 32'h003, 32'h5555, 32'h0, 0); settle();
      cmp("mis pulses", 32'(mis_cnt), 2);
      cmp("mis MREQ cycles", 32'(mreq_cnt), 0);
      cmp("mis stall cycles", 32'(stall_cnt), 0);

      // timeout
      clr_cnt();
      txn(0, F3_LW, 32'h040, 32'h0, 32'h0, 1000); settle();
      cmp("tmo MREQ cycles", 32'(mreq_cnt), T);
      cmp("tmo bus_error count", 32'(berr_cnt), 1);
      cmp("tmo mem_data", mem_data, 0);

      // reset in the middle of an SB
      @(posedge clk); #1;
      req_valid = 1; mem_read = 0; mem_write = 1; funct3 = F3_SB;
      alu_out_data = 32'h11; reg_data2 = 32'h1234_56A5; ACKD_n = 1;
      set_quiet(); exp_stall = 1;
      @(posedge clk); #1;
      ACKD_n = 1; set_quiet();
      exp_mreq = 1; exp_oe = 1; exp_stall = 1; exp_dad = 32'h10; exp_size = 2'b11;
      exp_write = 1; exp_dout = 32'hA5A5A5A5;
      @(negedge clk); #2;
      chk_en = 0; req_valid = 0; rst = 0;
      #1;
      cmp("sb busy ddt_oe", 32'(busy_oe), 1);
      cmp("sb busy ddt_out", busy_dout, 32'hA5A5A5A5);
      cmp("arst MREQ", 32'(MREQ), 0);
      cmp("arst ddt_oe", 32'(ddt_oe), 0);
      cmp("arst stall", 32'(stall), 0);
      cmp("arst DAD", DAD, 0);
      repeat (2) @(posedge clk);
      #3 rst = 1;
      m_data = 0; set_quiet(); chk_en = 1;
      txn(0, F3_LW, 32'h040, 32'h0, 32'hCAFEF00D, 1); settle();
      cmp("post-rst lw mem_data", mem_data, 32'hCAFEF00D);
      cmp("post-rst lw DAD", busy_dad, 32'h40);

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         logic        wr;
         logic [2:0]  f3;
         logic [31:0] addr;
         wr   = 1'($urandom_range(0, 1));
         f3   = wr ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
            else if (f3[1:0] == 2'b01) addr[0] = 1'b0;
         end
         txn(wr, f3, addr, $urandom, $urandom, $urandom_range(0, T + 2));
         idle($urandom_range(0, 2));
      end
      idle(2);
      settle();
      chk_en = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
